// File: rtl/physics_pkg.sv
// physics_pkg: constants shared by the soft-body update engine and its
// frame scheduler, plus the scheduler state encoding.
package physics_pkg;

  localparam int N_BODIES   = 2;
  localparam int N_NODES    = 8;
  localparam int N_SUBSTEPS = 4;
  localparam int TMO_CYCLES = 4096;

  localparam int BODY_W = $clog2(N_BODIES) + 1;
  localparam int SUB_W  = $clog2(N_SUBSTEPS) + 1;
  localparam int IDX_W  = $clog2(N_NODES) + 1;
  localparam int TMO_W  = $clog2(TMO_CYCLES) + 1;

  // Q16.16: one substep of a 60 Hz frame, and g in m/s^2
  localparam int                 FRAC_W  = 16;
  localparam logic        [31:0] DT      = 32'h0000_0111;
  localparam logic signed [31:0] GRAVITY = -32'sd642253;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/physics_step_scheduler_stream_indexer.sv
// stream_indexer: turns a valid pulse stream into indexed write enables.
// The count saturates at N so surplus pulses never write.
module stream_indexer
  import physics_pkg::*;
#(
  parameter int N = N_NODES,
  parameter int W = $clog2(N) + 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr_in,
  input  logic         en_in,
  input  logic         valid_in,
  output logic         wr_en_out,
  output logic [W-1:0] wr_idx_out
);

  localparam logic [W-1:0] FULL = W'(N);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         hit;

  assign hit        = en_in & valid_in & (cnt_q != FULL);
  assign wr_en_out  = hit;
  assign wr_idx_out = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in)
      cnt_d = '0;
    else if (hit)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/physics_step_scheduler.sv
// physics_step_scheduler: runs SUBSTEPS passes over every body per frame
// tick on the shared update engine and indexes its result streams.
module physics_step_scheduler
  import physics_pkg::*;
#(
  parameter int NUM_BODIES     = N_BODIES,
  parameter int NUM_NODES      = N_NODES,
  parameter int SUBSTEPS       = N_SUBSTEPS,
  parameter int TIMEOUT_CYCLES = TMO_CYCLES
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          frame_tick_in,
  input  logic                          enable_in,
  input  logic                          result_in,
  input  logic                          node_valid_in,
  input  logic                          velocity_valid_in,
  output logic                          begin_out,
  output logic [$clog2(NUM_BODIES):0]   body_sel_out,
  output logic [$clog2(SUBSTEPS):0]     substep_out,
  output logic                          node_wr_en_out,
  output logic [$clog2(NUM_NODES):0]    node_wr_idx_out,
  output logic                          vel_wr_en_out,
  output logic [$clog2(NUM_NODES):0]    vel_wr_idx_out,
  output logic                          busy_out,
  output logic                          frame_done_out,
  output logic                          overrun_out,
  output logic                          timeout_out
);

  localparam int BW = $clog2(NUM_BODIES) + 1;
  localparam int SW = $clog2(SUBSTEPS) + 1;
  localparam int IW = $clog2(NUM_NODES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [BW-1:0] LAST_BODY = BW'(NUM_BODIES - 1);
  localparam logic [SW-1:0] LAST_SUB  = SW'(SUBSTEPS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  sched_state_t  state_q;
  logic          tick_q;
  logic          pend_q;
  logic          begin_q;
  logic          busy_q;
  logic          done_q;
  logic          ovr_q;
  logic          tmo_q;
  logic [BW-1:0] body_q;
  logic [SW-1:0] sub_q;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;

  assign tmr_d = tmr_q + TW'(1);

  // Tick is registered first, so the engine sees begin two cycles later
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
      begin_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      body_q  <= '0;
      sub_q   <= '0;
      tmr_q   <= '0;
    end else begin
      tick_q  <= frame_tick_in & enable_in;
      begin_q <= 1'b0;
      done_q  <= 1'b0;
      if (tick_q && state_q != S_IDLE) begin
        if (pend_q)
          ovr_q <= 1'b1;
        else
          pend_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (tick_q || pend_q) begin
            body_q  <= '0;
            sub_q   <= '0;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
            begin_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmr_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (result_in) begin
            state_q <= S_ADVANCE;
          end else if (tmr_d == TMO_LAST) begin
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        S_ADVANCE: begin
          if (body_q != LAST_BODY) begin
            body_q  <= body_q + BW'(1);
            begin_q <= 1'b1;
            state_q <= S_LAUNCH;
          end else if (sub_q != LAST_SUB) begin
            body_q  <= '0;
            sub_q   <= sub_q + SW'(1);
            begin_q <= 1'b1;
            state_q <= S_LAUNCH;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  logic launch;
  logic in_wait;

  assign launch  = (state_q == S_LAUNCH);
  assign in_wait = (state_q == S_WAIT);

  stream_indexer #(.N(NUM_NODES), .W(IW)) u_node_idx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clr_in     (launch),
    .en_in      (in_wait),
    .valid_in   (node_valid_in),
    .wr_en_out  (node_wr_en_out),
    .wr_idx_out (node_wr_idx_out)
  );

  stream_indexer #(.N(NUM_NODES), .W(IW)) u_vel_idx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clr_in     (launch),
    .en_in      (in_wait),
    .valid_in   (velocity_valid_in),
    .wr_en_out  (vel_wr_en_out),
    .wr_idx_out (vel_wr_idx_out)
  );

  assign begin_out      = begin_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign overrun_out    = ovr_q;
  assign timeout_out    = tmo_q;
  assign body_sel_out   = body_q;
  assign substep_out    = sub_q;

endmodule

// File: tb/tb_physics_step_scheduler.sv
// tb_physics_step_scheduler: per-cycle vector table for the handshake,
// then engine-model runs for whole frames, overrun, timeout and reset.
module tb_physics_step_scheduler;

  localparam int NB  = 2;
  localparam int NN  = 8;
  localparam int SS  = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       frame_tick_in = 1'b0;
  logic       enable_in = 1'b0;
  logic       result_in = 1'b0;
  logic       node_valid_in = 1'b0;
  logic       velocity_valid_in = 1'b0;
  logic       begin_out;
  logic [1:0] body_sel_out;
  logic [2:0] substep_out;
  logic       node_wr_en_out;
  logic [3:0] node_wr_idx_out;
  logic       vel_wr_en_out;
  logic [3:0] vel_wr_idx_out;
  logic       busy_out;
  logic       frame_done_out;
  logic       overrun_out;
  logic       timeout_out;

  physics_step_scheduler #(
    .NUM_BODIES     (NB),
    .NUM_NODES      (NN),
    .SUBSTEPS       (SS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .frame_tick_in     (frame_tick_in),
    .enable_in         (enable_in),
    .result_in         (result_in),
    .node_valid_in     (node_valid_in),
    .velocity_valid_in (velocity_valid_in),
    .begin_out         (begin_out),
    .body_sel_out      (body_sel_out),
    .substep_out       (substep_out),
    .node_wr_en_out    (node_wr_en_out),
    .node_wr_idx_out   (node_wr_idx_out),
    .vel_wr_en_out     (vel_wr_en_out),
    .vel_wr_idx_out    (vel_wr_idx_out),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .overrun_out       (overrun_out),
    .timeout_out       (timeout_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tick, en, res, nv, vv;
    bit beg, busy, nwe, vwe;
    int nidx, vidx, body;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int beg_q[$];
  int done_q[$];
  int n_nwr, n_vwr, ovr_first, tmo_first;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " begin"}, int'(begin_out), 0);
    chk({nm, " busy"}, int'(busy_out), 0);
    chk({nm, " done"}, int'(frame_done_out), 0);
    chk({nm, " nwe"}, int'(node_wr_en_out), 0);
    chk({nm, " vwe"}, int'(vel_wr_en_out), 0);
    chk({nm, " nidx"}, int'(node_wr_idx_out), 0);
    chk({nm, " vidx"}, int'(vel_wr_idx_out), 0);
    chk({nm, " body"}, int'(body_sel_out), 0);
    chk({nm, " sub"}, int'(substep_out), 0);
    chk({nm, " ovr"}, int'(overrun_out), 0);
    chk({nm, " tmo"}, int'(timeout_out), 0);
  endtask

  task automatic idle_inputs();
    rst_in = 1'b0;
    frame_tick_in = 1'b0;
    enable_in = 1'b1;
    result_in = 1'b0;
    node_valid_in = 1'b0;
    velocity_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  // Engine model: pulses at t=2..2+n-1 after begin, result at t=res_dly
  task automatic run(input int ncyc, input int tk0, input int tk1,
                     input int tk2, input int res_dly, input int nn,
                     input int nv, input int rst_at);
    int  last_b = 0;
    int  t, kf = 0, ncnt = 0, vcnt = 0;
    bit  act = 0;
    beg_q.delete();
    done_q.delete();
    n_nwr = 0;
    n_vwr = 0;
    ovr_first = -1;
    tmo_first = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      t = c - last_b;
      rst_in = (c == rst_at);
      frame_tick_in = (c == tk0 || c == tk1 || c == tk2);
      enable_in = 1'b1;
      result_in = act && res_dly > 0 && t == res_dly;
      node_valid_in = act && t >= 2 && t < 2 + nn;
      velocity_valid_in = act && t >= 2 && t < 2 + nv;
      #1;
      if (c == rst_at + 1) begin
        chk_zero("after_reset");
        act = 0;
        kf = 0;
      end
      if (begin_out) begin
        chk($sformatf("step%0d body", kf), int'(body_sel_out), kf % NB);
        chk($sformatf("step%0d sub", kf), int'(substep_out), kf / NB);
        if (kf > 0)
          chk($sformatf("step%0d gap", kf), c - last_b, res_dly + 2);
        beg_q.push_back(c);
        last_b = c;
        act = 1;
        kf++;
        ncnt = 0;
        vcnt = 0;
      end
      if (result_in && node_valid_in && act) begin
        chk("simul nwe", int'(node_wr_en_out), 1);
        chk("simul vwe", int'(vel_wr_en_out), int'(velocity_valid_in));
      end
      if (node_wr_en_out) begin
        chk("nidx", int'(node_wr_idx_out), ncnt);
        ncnt++;
        n_nwr++;
      end
      if (vel_wr_en_out) begin
        chk("vidx", int'(vel_wr_idx_out), vcnt);
        vcnt++;
        n_vwr++;
      end
      if (frame_done_out) begin
        done_q.push_back(c);
        act = 0;
        kf = 0;
      end
      if (overrun_out && ovr_first < 0) ovr_first = c;
      if (timeout_out && tmo_first < 0) tmo_first = c;
    end
    idle_inputs();
  endtask

  vec_t tbl[13];

  initial begin
    //            tick en res nv vv   beg busy nwe vwe nidx vidx body
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 1,  1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 0,  0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 1,  0, 1, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 1,  0, 1, 0, 1, 2, 1, 0};
    tbl[9]  = '{0, 1, 1, 1, 1,  0, 1, 1, 1, 2, 2, 0};
    tbl[10] = '{0, 1, 0, 1, 1,  0, 1, 0, 0, 3, 3, 0};
    tbl[11] = '{0, 1, 0, 0, 0,  1, 1, 0, 0, 3, 3, 1};
    tbl[12] = '{0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    #1;
    chk_zero("reset");

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      frame_tick_in = tbl[i].tick;
      enable_in = tbl[i].en;
      result_in = tbl[i].res;
      node_valid_in = tbl[i].nv;
      velocity_valid_in = tbl[i].vv;
      #1;
      chk($sformatf("row%0d begin", i), int'(begin_out), int'(tbl[i].beg));
      chk($sformatf("row%0d busy", i), int'(busy_out), int'(tbl[i].busy));
      chk($sformatf("row%0d nwe", i), int'(node_wr_en_out), int'(tbl[i].nwe));
      chk($sformatf("row%0d vwe", i), int'(vel_wr_en_out), int'(tbl[i].vwe));
      chk($sformatf("row%0d nidx", i), int'(node_wr_idx_out), tbl[i].nidx);
      chk($sformatf("row%0d vidx", i), int'(vel_wr_idx_out), tbl[i].vidx);
      chk($sformatf("row%0d body", i), int'(body_sel_out), tbl[i].body);
    end

    // Basic frame
    do_reset();
    run(460, 10, -1, -1, 50, 8, 8, -10);
    chk("A begins", beg_q.size(), 8);
    chk("A first begin", beg_q.size() > 0 ? beg_q[0] : -1, 12);
    chk("A dones", done_q.size(), 1);
    chk("A done cycle", done_q.size() > 0 ? done_q[0] : -1, 428);
    chk("A node writes", n_nwr, 64);
    chk("A vel writes", n_vwr, 64);
    chk("A busy end", int'(busy_out), 0);
    chk("A overrun", ovr_first, -1);
    chk("A timeout", tmo_first, -1);

    // Overrun with pending relaunch, plus node stream overflow
    do_reset();
    run(880, 10, 20, 30, 50, 10, 8, -10);
    chk("B overrun cycle", ovr_first, 32);
    chk("B begins", beg_q.size(), 16);
    chk("B dones", done_q.size(), 2);
    chk("B relaunch", beg_q.size() > 8 ? beg_q[8] : -1, 430);
    chk("B done2 cycle", done_q.size() > 1 ? done_q[1] : -1, 846);
    chk("B node writes", n_nwr, 128);
    chk("B vel writes", n_vwr, 128);
    chk("B busy end", int'(busy_out), 0);
    chk("B overrun sticky", int'(overrun_out), 1);

    // Last pulses coincide with result
    do_reset();
    run(130, 10, -1, -1, 9, 8, 8, -10);
    chk("C begins", beg_q.size(), 8);
    chk("C done cycle", done_q.size() > 0 ? done_q[0] : -1, 100);
    chk("C node writes", n_nwr, 64);
    chk("C vel writes", n_vwr, 64);

    // Engine never responds
    do_reset();
    run(150, 10, -1, -1, 0, 8, 8, -10);
    chk("D begins", beg_q.size(), 1);
    chk("D timeout cycle", tmo_first, 76);
    chk("D done cycle", done_q.size() > 0 ? done_q[0] : -1, 76);
    chk("D dones", done_q.size(), 1);
    chk("D busy end", int'(busy_out), 0);
    chk("D timeout sticky", int'(timeout_out), 1);

    // Reset during body 1, substep 2, then a fresh frame
    do_reset();
    run(750, 10, 300, -1, 50, 8, 8, 290);
    chk("E begins", beg_q.size(), 14);
    chk("E restart", beg_q.size() > 6 ? beg_q[6] : -1, 302);
    chk("E dones", done_q.size(), 1);
    chk("E done cycle", done_q.size() > 0 ? done_q[0] : -1, 718);
    chk("E busy end", int'(busy_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
